// File: rtl/lsu_axi.sv
// Load/store unit bridging a single-outstanding request port onto AXI-lite.
// Handles byte lanes, strobes, sign extension and misalignment errors.
module lsu_axi #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_ren_i,
  input  logic                req_wen_i,
  input  logic                req_signed_i,
  input  logic [1:0]          req_size_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,

  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DATA_W-1:0]   resp_rdata_o,
  output logic                resp_err_o,

  output logic [ADDR_W-1:0]   araddr_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rvalid_i,
  output logic                rready_o,

  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdAddr = 3'd1;
  localparam logic [2:0] StRdData = 3'd2;
  localparam logic [2:0] StWrReq  = 3'd3;
  localparam logic [2:0] StWrResp = 3'd4;
  localparam logic [2:0] StResp   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  // Request decode
  logic [OFF_W-1:0]  req_off;
  logic [ADDR_W-1:0] req_align;
  logic [DATA_W-1:0] req_wsh;
  logic [STRB_W-1:0] req_strb;
  logic              req_misaligned;
  logic              req_bad;

  assign req_off   = req_addr_i[OFF_W-1:0];
  assign req_align = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign req_wsh   = req_wdata_i << {req_off, 3'b000};

  always_comb begin
    int req_bytes;
    req_bytes = 1 << req_size_i;
    unique case (req_size_i)
      2'd0:    req_misaligned = 1'b0;
      2'd1:    req_misaligned = req_addr_i[0];
      2'd2:    req_misaligned = |req_addr_i[1:0];
      default: req_misaligned = |req_addr_i[2:0];
    endcase
    req_bad = req_misaligned || (req_bytes > int'(STRB_W)) || (req_ren_i && req_wen_i);
    for (int i = 0; i < int'(STRB_W); i++) begin
      req_strb[i] = (i >= int'(req_off)) && (i < int'(req_off) + req_bytes);
    end
  end

  // Read-data lane extraction with sign/zero extension
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] rd_ext;

  assign rd_shift = rdata_i >> {off_q, 3'b000};

  always_comb begin
    int   nbits;
    logic sbit;
    nbits = 8 << size_q;
    sbit  = 1'b0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i == nbits - 1) sbit = rd_shift[i];
    end
    for (int i = 0; i < int'(DATA_W); i++) begin
      rd_ext[i] = (i < nbits) ? rd_shift[i] : (signed_q & sbit);
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    off_d     = off_q;
    size_d    = size_q;
    signed_d  = signed_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d    = req_align;
          wdata_d   = req_wsh;
          wstrb_d   = req_strb;
          off_d     = req_off;
          size_d    = req_size_i;
          signed_d  = req_signed_i;
          rdata_d   = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else if (req_ren_i) begin
            state_d = StRdAddr;
          end else if (req_wen_i) begin
            state_d = StWrReq;
          end else begin
            state_d = StResp;
          end
        end
      end
      StRdAddr: begin
        if (arready_i) state_d = StRdData;
      end
      StRdData: begin
        if (rvalid_i) begin
          rdata_d = rd_ext;
          err_d   = |rresp_i;
          state_d = StResp;
        end
      end
      StWrReq: begin
        // AW and W complete independently; move on once both are done.
        if (awready_i) aw_done_d = 1'b1;
        if (wready_i)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (bvalid_i) begin
          rdata_d = '0;
          err_d   = |bresp_i;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      off_q     <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      off_q     <= off_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // All outputs decode registered state only.
  assign req_ready_o  = (state_q == StIdle);
  assign arvalid_o    = (state_q == StRdAddr);
  assign rready_o     = (state_q == StRdData);
  assign awvalid_o    = (state_q == StWrReq) && !aw_done_q;
  assign wvalid_o     = (state_q == StWrReq) && !w_done_q;
  assign bready_o     = (state_q == StWrResp);
  assign resp_valid_o = (state_q == StResp);
  assign resp_err_o   = err_q;
  assign resp_rdata_o = rdata_q;
  assign araddr_o     = addr_q;
  assign awaddr_o     = addr_q;
  assign wdata_o      = wdata_q;
  assign wstrb_o      = wstrb_q;

endmodule

// File: tb/tb_lsu_axi.sv
// Scoreboard bench for lsu_axi: AXI-lite slave model with programmable waits,
// expected responses queued at issue and compared as the DUT answers.
module tb_lsu_axi;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_ready;
  logic        req_ren = 1'b0, req_wen = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, arready, rready, awvalid, awready, wvalid, wready, bready;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        rvalid, bvalid;
  logic [3:0]  wstrb;

  lsu_axi #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_ren_i(req_ren),
    .req_wen_i(req_wen), .req_signed_i(req_signed), .req_size_i(req_size),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err),
    .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready), .rdata_i(rdata),
    .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
    .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready), .wdata_o(wdata),
    .wstrb_o(wstrb), .wvalid_o(wvalid), .wready_i(wready), .bresp_i(bresp),
    .bvalid_i(bvalid), .bready_o(bready)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;  // 0 = not checked
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slave knobs and expectations
  int          ar_delay = 0, aw_delay = 0, w_delay = 0, resp_stall = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = 2'd0, s_bresp = 2'd0;
  logic [31:0] exp_araddr = '0, exp_awaddr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  int          ar_count = 0, aw_count = 0;

  int   ar_cnt, aw_cnt, w_cnt, st_cnt;
  logic aw_seen, w_seen;
  assign arready    = (ar_cnt >= ar_delay);
  assign awready    = (aw_cnt >= aw_delay);
  assign wready     = (w_cnt >= w_delay);
  assign resp_ready = (st_cnt >= resp_stall);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; st_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0;
      rvalid <= 1'b0; bvalid <= 1'b0; rdata <= '0; rresp <= '0; bresp <= '0;
    end else begin
      if (arvalid && !arready) ar_cnt <= ar_cnt + 1;
      else if (arvalid && arready) begin
        ar_cnt <= 0; rvalid <= 1'b1; rdata <= s_rdata; rresp <= s_rresp;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
      else if (awvalid) aw_cnt <= 0;
      if (wvalid && !wready) w_cnt <= w_cnt + 1;
      else if (wvalid) w_cnt <= 0;
      if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
        bvalid <= 1'b1; bresp <= s_bresp; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        aw_seen <= aw_seen || (awvalid && awready);
        w_seen  <= w_seen || (wvalid && wready);
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (resp_valid && !resp_ready) st_cnt <= st_cnt + 1;
      else if (resp_valid) st_cnt <= 0;
    end
  end

  int cyc = 0, acc_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) acc_cyc <= cyc;
  end

  // Channel and response monitor, sampled mid-cycle
  logic        in_resp = 1'b0;
  logic [31:0] held_rdata;
  logic        held_err;
  exp_t        e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (arvalid && arready) begin
        ar_count++;
        check("araddr", araddr, exp_araddr);
      end
      if (awvalid && awready) begin
        aw_count++;
        check("awaddr", awaddr, exp_awaddr);
      end
      if (wvalid && wready) begin
        check("wdata", wdata, exp_wdata);
        check("wstrb", wstrb, exp_wstrb);
      end
      if (aw_seen) check("awvalid_drop", awvalid, 0);
      if (w_seen)  check("wvalid_drop", wvalid, 0);
      if (bready)  check("bready_order", {awvalid, wvalid}, 0);
      if (resp_valid) begin
        if (!in_resp) begin
          in_resp = 1'b1;
          if (sb.size() == 0) check("unexpected_resp", resp_valid, 0);
          else begin
            e = sb.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", resp_err, e.err);
            if (e.lat > 0) check("latency", cyc - acc_cyc, e.lat);
            held_rdata = resp_rdata;
            held_err   = resp_err;
          end
        end else begin
          check("hold_rdata", resp_rdata, held_rdata);
          check("hold_err", resp_err, held_err);
        end
        if (resp_ready) in_resp = 1'b0;
      end
    end
  end

  task automatic send(input logic ren, input logic wen, input logic sgn, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wd);
    logic acc;
    acc = 1'b0;
    req_ren = ren; req_wen = wen; req_signed = sgn; req_size = sz;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    req_valid = 1'b0;
    if (!acc) check("req_accept_timeout", acc, 1);
  endtask

  task automatic wait_done();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !resp_valid) begin done = 1'b1; break; end
    end
    if (!done) check("resp_timeout", done, 1);
  endtask

  task automatic txn(input logic ren, input logic wen, input logic sgn, input logic [1:0] sz,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] erd, input logic eerr, input int elat);
    exp_t x;
    x.rdata = erd; x.err = eerr; x.lat = elat;
    sb.push_back(x);
    send(ren, wen, sgn, sz, addr, wd);
    wait_done();
  endtask

  int   ar_before, aw_before;
  logic seen;

  initial begin
    #2;
    check("rst_arvalid", arvalid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_awvalid_wvalid", {awvalid, wvalid, bready, rready}, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    check("req_ready_after_rst", req_ready, 1);

    // Loads
    exp_araddr = 32'h8000_0000; s_rdata = 32'h80FF_FFFF;
    txn(1, 0, 1, 2'd0, 32'h8000_0003, '0, 32'hFFFF_FF80, 0, 3);
    txn(1, 0, 0, 2'd0, 32'h8000_0003, '0, 32'h0000_0080, 0, 3);
    s_rdata = 32'h8001_1234;
    txn(1, 0, 1, 2'd1, 32'h8000_0002, '0, 32'hFFFF_8001, 0, 3);
    txn(1, 0, 1, 2'd1, 32'h8000_0000, '0, 32'h0000_1234, 0, 3);
    exp_araddr = 32'h8000_0004; s_rdata = 32'hDEAD_BEEF;
    txn(1, 0, 0, 2'd2, 32'h8000_0004, '0, 32'hDEAD_BEEF, 0, 3);
    ar_delay = 2;
    txn(1, 0, 0, 2'd0, 32'h8000_0005, '0, 32'h0000_00BE, 0, 0);
    ar_delay = 0;

    // Stores
    exp_awaddr = 32'h8000_0000; exp_wdata = 32'h1234_0000; exp_wstrb = 4'b1100;
    txn(0, 1, 0, 2'd1, 32'h8000_0002, 32'h0000_1234, '0, 0, 3);
    exp_wdata = 32'h0000_AB00; exp_wstrb = 4'b0010; aw_delay = 3;
    txn(0, 1, 0, 2'd0, 32'h8000_0001, 32'h0000_00AB, '0, 0, 0);
    aw_delay = 0; w_delay = 2; exp_wdata = 32'hCAFE_F00D; exp_wstrb = 4'b1111;
    txn(0, 1, 0, 2'd2, 32'h8000_0000, 32'hCAFE_F00D, '0, 0, 0);
    w_delay = 0; s_bresp = 2'b11;
    txn(0, 1, 0, 2'd2, 32'h8000_0000, 32'hCAFE_F00D, '0, 1, 3);
    s_bresp = 2'b00;

    // Errors and no-op: no bus traffic allowed
    ar_before = ar_count; aw_before = aw_count;
    txn(1, 0, 0, 2'd2, 32'h8000_0002, '0, '0, 1, 1);
    txn(0, 1, 0, 2'd1, 32'h8000_0001, '0, '0, 1, 1);
    txn(1, 0, 0, 2'd3, 32'h8000_0000, '0, '0, 1, 1);
    txn(1, 1, 0, 2'd2, 32'h8000_0000, '0, '0, 1, 1);
    txn(0, 0, 0, 2'd2, 32'h8000_0000, '0, '0, 0, 1);
    check("no_ar_traffic", ar_count - ar_before, 0);
    check("no_aw_traffic", aw_count - aw_before, 0);

    // Slave error with a stalled consumer
    s_rresp = 2'b10; s_rdata = 32'h1122_3344; exp_araddr = 32'h8000_0000; resp_stall = 4;
    txn(1, 0, 0, 2'd2, 32'h8000_0000, '0, 32'h1122_3344, 1, 3);
    s_rresp = 2'b00; resp_stall = 0;

    // Reset while the AR channel is stalled
    ar_delay = 1000;
    send(1, 0, 0, 2'd2, 32'h8000_0000, '0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (arvalid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("arvalid_before_rst", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arvalid_in_rst", arvalid, 0);
    check("resp_in_rst", {resp_valid, resp_err}, 0);
    check("araddr_in_rst", araddr, 0);
    @(negedge clk); rst_n = 1'b1; ar_delay = 0;
    @(posedge clk); #1;
    check("req_ready_after_midrst", req_ready, 1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid || arvalid) seen = 1'b1;
    end
    check("no_stale_resp", seen, 0);
    s_rdata = 32'h0000_7F00;
    txn(1, 0, 1, 2'd0, 32'h8000_0001, '0, 32'h0000_007F, 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lsu_axi.md
LSU_AXI -- requirements
Module: lsu_axi

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning bus data width; legal values are 32 and 64.
REQ-003 SHALL have port clk  in  1  clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, forming the upstream request handshake.
REQ-006 SHALL have ports req_ren in 1, req_wen in 1, req_signed in 1, req_size in 2 (0=B, 1=H, 2=W, 3=D).
REQ-007 SHALL have ports req_addr in ADDR_W and req_wdata in DATA_W; req_wdata is LSB-justified.
REQ-008 SHALL have ports resp_valid out 1, resp_ready in 1, resp_rdata out DATA_W, resp_err out 1.
REQ-009 SHALL have AXI-lite read ports araddr out ADDR_W, arvalid out 1, arready in 1, rdata in DATA_W, rresp in 2, rvalid in 1, rready out 1.
REQ-010 SHALL have AXI-lite write ports awaddr out ADDR_W, awvalid out 1, awready in 1, wdata out DATA_W, wstrb out DATA_W/8, wvalid out 1, wready in 1, bresp in 2, bvalid in 1, bready out 1.

Function
REQ-011 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
REQ-012 SHALL assert req_ready only in IDLE; a request is accepted on req_valid && req_ready.
REQ-013 SHALL, on acceptance, register addr, wdata, size, signed, and the byte offset addr[log2(DATA_W/8)-1:0].
REQ-014 SHALL transition to RESP with resp_err=1 and no bus traffic when the request is misaligned (addr not a multiple of 2^size), when 2^size > DATA_W/8, or when ren && wen.
REQ-015 SHALL transition to RESP with resp_err=0 and resp_rdata=0 when neither ren nor wen is set.
REQ-016 SHALL, for a legal read, enter RD_ADDR with arvalid=1 and araddr=addr aligned down to the bus width, holding both stable until arready.
REQ-017 SHALL, on the ar handshake, enter RD_DATA with rready=1, then capture rdata and rresp on rvalid.
REQ-018 SHALL derive resp_rdata by shifting the captured rdata right by 8*offset and then masking to 2^size bytes, sign-extending from the top selected bit when req_signed=1 and zero-extending otherwise.
REQ-019 SHALL, for a legal write, enter WR_REQ with awvalid=1 and wvalid=1 together, awaddr aligned, wdata=req_wdata<<(8*offset), and wstrb holding 2^size ones starting at bit offset.
REQ-020 SHALL drop awvalid and wvalid independently on their own handshakes (either order, or the same cycle), and SHALL leave WR_REQ only after both have completed.
REQ-021 SHALL assert bready=1 in WR_RESP, and on bvalid enter RESP with resp_rdata=0.
REQ-022 SHALL set resp_err=1 when the captured rresp or bresp is nonzero (SLVERR or DECERR).
REQ-023 SHALL hold resp_valid=1 in RESP with stable resp_rdata and resp_err until resp_ready, then return to IDLE.
REQ-024 SHALL have minimum latency, from acceptance to resp_valid, of 3 cycles for a read (zero-wait slave) and 3 cycles for a write.
REQ-025 SHALL keep at most one outstanding transaction; no new request is accepted before the resp handshake completes.
REQ-026 SHALL be Moore for all outputs, with no combinational path from any input to any valid/ready output.

Reset
REQ-027 SHALL, on rst=0 at any time including mid-transaction, immediately force state IDLE and drive arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err to 0 and all address/data registers to 0.
REQ-028 SHALL drive req_ready=1 from the first clock edge after rst deasserts.

Verification
REQ-029 SHALL pass: with DATA_W=32, LB at addr 0x8000_0003, rdata=0x80FF_FFFF, signed=1 -> araddr=0x8000_0000, resp_rdata=0xFFFF_FF80, resp_err=0.
REQ-030 SHALL pass: SH at addr 0x8000_0002 with wdata 0x1234 -> awaddr=0x8000_0000, wdata=0x1234_0000, wstrb=4'b1100, resp after bvalid with bresp=0.
REQ-031 SHALL pass: awready arriving 3 cycles after wready -> awvalid and wvalid each drop after their own handshake, and bready rises only after both have dropped.
REQ-032 SHALL pass: LW at addr 0x8000_0002 -> no arvalid ever, resp_valid with resp_err=1 three cycles later... corrected: resp_valid with resp_err=1 one cycle after acceptance.
REQ-033 SHALL pass: rresp=2'b10 on a read -> resp_err=1, and a resp_ready stall of 4 cycles holds resp_rdata and resp_err stable throughout.
REQ-034 SHALL pass: rst asserted while arvalid=1 and arready=0 -> arvalid=0 immediately, then req_ready=1 after release with no stale response issued.
